// File: rtl/test.sv
`default_nettype none
// ============================================================================
// Module   : test
// Purpose  : Registered MIPS instruction-class decoder (opcode/funct -> 3-bit
//            class). Define TEST_EXT_OPS_EN to add addiu/bne/lb/sb/slt/jalr.
// Revision : 1.0 - initial release
// ============================================================================
module test (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IM_D,
    output logic [2:0]  out
);

    localparam logic [2:0] c_NONE   = 3'b000;
    localparam logic [2:0] c_R_ALU  = 3'b001;
    localparam logic [2:0] c_I_ALU  = 3'b010;
    localparam logic [2:0] c_LOAD   = 3'b011;
    localparam logic [2:0] c_STORE  = 3'b100;
    localparam logic [2:0] c_BRANCH = 3'b101;
    localparam logic [2:0] c_JUMP   = 3'b110;
    localparam logic [2:0] c_JREG   = 3'b111;

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic [2:0] w_class;
    logic [2:0] r_out;

    assign w_opcode = IM_D[31:26];
    assign w_funct  = IM_D[5:0];

    always_comb begin
        w_class = c_NONE;
        // The all-zero nop would otherwise fall into the R-type funct table.
        if (IM_D != 32'h0000_0000) begin
            case (w_opcode)
                6'b000000: begin
                    case (w_funct)
                        6'b100001,
                        6'b100011: w_class = c_R_ALU;
                        6'b001000: w_class = c_JREG;
`ifdef TEST_EXT_OPS_EN
                        6'b101010: w_class = c_R_ALU;
                        6'b001001: w_class = c_JREG;
`endif
                        default:   w_class = c_NONE;
                    endcase
                end
                6'b001101,
                6'b001111: w_class = c_I_ALU;
                6'b100011: w_class = c_LOAD;
                6'b101011: w_class = c_STORE;
                6'b000100: w_class = c_BRANCH;
                6'b000010,
                6'b000011: w_class = c_JUMP;
`ifdef TEST_EXT_OPS_EN
                6'b001001: w_class = c_I_ALU;
                6'b000101: w_class = c_BRANCH;
                6'b100000: w_class = c_LOAD;
                6'b101000: w_class = c_STORE;
`endif
                default:   w_class = c_NONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= c_NONE;
        end else begin
            r_out <= w_class;
        end
    end

    assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_test.sv
`default_nettype none
// ============================================================================
// Module   : tb_test
// Purpose  : Self-checking bench for the instruction-class decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_test;

    logic        clk;
    logic        reset;
    logic [31:0] IM_D;
    logic [2:0]  out;

    int checks;
    int errors;

    test dut (
        .clk   (clk),
        .reset (reset),
        .IM_D  (IM_D),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef TEST_EXT_OPS_EN
    localparam bit c_EXT = 1'b1;
`else
    localparam bit c_EXT = 1'b0;
`endif

    // Lookup tables straight from the class listing; absent key means illegal.
    logic [2:0] op_map [int];
    logic [2:0] fn_map [int];

    initial begin
        op_map[6'b001101] = 3'd2;  op_map[6'b001111] = 3'd2;
        op_map[6'b100011] = 3'd3;  op_map[6'b101011] = 3'd4;
        op_map[6'b000100] = 3'd5;  op_map[6'b000010] = 3'd6;
        op_map[6'b000011] = 3'd6;
        fn_map[6'b100001] = 3'd1;  fn_map[6'b100011] = 3'd1;
        fn_map[6'b001000] = 3'd7;
        if (c_EXT) begin
            op_map[6'b001001] = 3'd2;  op_map[6'b000101] = 3'd5;
            op_map[6'b100000] = 3'd3;  op_map[6'b101000] = 3'd4;
            fn_map[6'b101010] = 3'd1;  fn_map[6'b001001] = 3'd7;
        end
    end

    function automatic logic [2:0] classify(input logic [31:0] w);
        int op;
        int fn;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        if (w == 32'h0) return 3'd0;
        if (op == 0) return fn_map.exists(fn) ? fn_map[fn] : 3'd0;
        return op_map.exists(op) ? op_map[op] : 3'd0;
    endfunction

    // Reference of what out must hold after each rising edge.
    logic [2:0] model_out;
    bit         model_valid = 1'b0;

    always @(posedge clk) begin
        model_out   <= reset ? 3'd0 : classify(IM_D);
        model_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (out !== model_out) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t IM_D=%h out=%b expected=%b", $time, IM_D, out, model_out);
            end
        end
    end

    task automatic step(input logic [31:0] im, input logic r, input logic [2:0] exp, input string name);
        @(negedge clk);
        IM_D  = im;
        reset = r;
        @(posedge clk);
        #1;
        checks++;
        if (out !== exp) begin
            errors++;
            $display("FAIL %s out=%b expected=%b", name, out, exp);
        end
    endtask

    task automatic pin(input logic [31:0] w, input logic [2:0] exp, input string name);
        checks++;
        if (classify(w) !== exp) begin
            errors++;
            $display("FAIL model_%s got=%b expected=%b", name, classify(w), exp);
        end
    endtask

    logic [5:0] op_pool [14];
    logic [5:0] fn_pool [8];

    initial begin
        logic [31:0] w;
        logic [2:0]  ext_addiu;
        logic [2:0]  ext_bne;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        IM_D   = 32'h0;
        op_pool = '{6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03,
                    6'h09, 6'h05, 6'h20, 6'h28, 6'h00, 6'h3F};
        fn_pool = '{6'h21, 6'h23, 6'h08, 6'h2A, 6'h09, 6'h25, 6'h20, 6'h00};
        ext_addiu = c_EXT ? 3'b010 : 3'b000;
        ext_bne   = c_EXT ? 3'b101 : 3'b000;

        repeat (2) @(posedge clk);

        pin(32'h00221821, 3'b001, "addu");
        pin(32'h3C011234, 3'b010, "lui");
        pin(32'h00000000, 3'b000, "nop");
        pin(32'h03E00008, 3'b111, "jr");

        step(32'h3C011234, 1'b1, 3'b000, "reset_lui");
        step(32'h3C011234, 1'b0, 3'b010, "release_lui");
        step(32'hFFFFFFFF, 1'b0, 3'b000, "all_ones");
        checks++;
        if (out[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL all_ones_low out=%b expected=00", out[1:0]);
        end
        step(32'h00221821, 1'b0, 3'b001, "addu");
        step(32'h8C220004, 1'b0, 3'b011, "lw");
        step(32'hAC220004, 1'b0, 3'b100, "sw");
        step(32'h1022FFFF, 1'b0, 3'b101, "beq");
        step(32'h0C000010, 1'b0, 3'b110, "jal");
        step(32'h03E00008, 1'b0, 3'b111, "jr");
        step(32'h00000000, 1'b0, 3'b000, "nop");
        step(32'h00000025, 1'b0, 3'b000, "or_unlisted");
        step(32'h24210001, 1'b0, ext_addiu, "addiu");
        step(32'h14220003, 1'b0, ext_bne, "bne");
        step(32'h8C220004, 1'b0, 3'b011, "lw_pre_reset");
        step(32'hAC220004, 1'b1, 3'b000, "sw_under_reset");
        step(32'hAC220004, 1'b0, 3'b100, "sw_after_reset");

        // Randomised traffic; the per-cycle compare process checks every edge.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            w = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                w[31:26] = op_pool[$urandom_range(0, 13)];
                if (w[31:26] == 6'h00) w[5:0] = fn_pool[$urandom_range(0, 7)];
            end
            if ($urandom_range(0, 49) == 0) w = 32'h0;
            IM_D  = w;
            reset = ($urandom_range(0, 31) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
